// File: rtl/hi_reader_seq_if.sv
// Command-byte stream between the ARM-facing command path and the frame sequencer.
// The master supplies bytes; the slave (sequencer) signals acceptance with tx_ready.
interface hi_reader_seq_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_byte, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_byte, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/hi_reader_seq.sv
// HF reader frame sequencer: serialises command bytes LSB first onto mod_out,
// then runs a frame-delay guard and a receive window with timeout.
module hi_reader_seq #(
  parameter int         ETU_CLKS     = 128,
  parameter logic [3:0] MODE_RX      = 4'd0,
  parameter logic [3:0] MODE_FULL    = 4'd4,
  parameter logic [3:0] MODE_SHALLOW = 4'd5
) (
  input  logic               ck_1356meg,
  input  logic               rst_n,
  input  logic               start,
  input  logic               shallow,
  hi_reader_seq_if.slave     tx,
  input  logic [15:0]        fdt,
  input  logic [15:0]        rx_window,
  input  logic               rx_done,
  output logic [3:0]         minor_mode,
  output logic               mod_out,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TX, S_GUARD, S_RX} state_t;

  localparam logic [15:0] ETU_LAST = 16'(ETU_CLKS - 1);

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] etu_q, etu_d;
  logic [15:0] cnt_q, cnt_d;        // shared by GUARD and RX, never live in both
  logic        last_q, last_d;
  logic        shallow_q, shallow_d;
  logic [15:0] fdt_q, fdt_d;
  logic [15:0] win_q, win_d;
  logic        done_d, timeout_d, err_d;
  logic        mod_d;
  logic [3:0]  mode_d;

  logic etu_end, byte_end, accept;
  logic guard_end, win_end;

  assign etu_end   = (etu_q == ETU_LAST);
  assign byte_end  = etu_end && (bit_q == 3'd7);
  // Only called on GUARD/RX cycles, where fdt_q/win_q bound the count.
  assign guard_end = ({1'b0, cnt_q} + 17'd1) >= {1'b0, fdt_q};
  assign win_end   = ({1'b0, cnt_q} + 17'd1) >= {1'b0, win_q};

  assign tx.tx_ready = (state_q == S_LOAD) || ((state_q == S_TX) && byte_end && !last_q);
  assign accept      = tx.tx_ready && tx.tx_valid;
  assign busy        = (state_q != S_IDLE);

  // NOTE: every signal written here gets its default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    etu_d     = etu_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    shallow_d = shallow_q;
    fdt_d     = fdt_q;
    win_d     = win_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shallow_d = shallow;
          fdt_d     = fdt;
          win_d     = rx_window;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          shift_d = tx.tx_byte;
          last_d  = tx.tx_last;
          bit_d   = 3'd0;
          etu_d   = 16'd0;
          state_d = S_TX;
        end
      end
      S_TX: begin
        if (!etu_end) begin
          etu_d = etu_q + 16'd1;
        end else begin
          etu_d = 16'd0;
          if (bit_q != 3'd7) begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end else if (last_q) begin
            cnt_d   = 16'd0;
            state_d = (fdt_q == 16'd0) ? S_RX : S_GUARD;
          end else if (tx.tx_valid) begin
            // Back-to-back byte: bit 0 follows bit 7 with no gap.
            shift_d = tx.tx_byte;
            last_d  = tx.tx_last;
            bit_d   = 3'd0;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_GUARD: begin
        if (guard_end) begin
          cnt_d   = 16'd0;
          state_d = S_RX;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RX: begin
        if (rx_done) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (win_end) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values so they are valid on the first cycle of each state.
    mod_d  = (state_d == S_TX) ? shift_d[0] : 1'b0;
    mode_d = (state_d == S_TX) ? (shallow_d ? MODE_SHALLOW : MODE_FULL) : MODE_RX;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= 8'd0;
      bit_q      <= 3'd0;
      etu_q      <= 16'd0;
      cnt_q      <= 16'd0;
      last_q     <= 1'b0;
      shallow_q  <= 1'b0;
      fdt_q      <= 16'd0;
      win_q      <= 16'd0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      err        <= 1'b0;
      mod_out    <= 1'b0;
      minor_mode <= MODE_RX;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      etu_q      <= etu_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      shallow_q  <= shallow_d;
      fdt_q      <= fdt_d;
      win_q      <= win_d;
      done       <= done_d;
      timeout    <= timeout_d;
      err        <= err_d;
      mod_out    <= mod_d;
      minor_mode <= mode_d;
    end
  end

endmodule

// File: tb/tb_hi_reader_seq.sv
// Bench for hi_reader_seq: a frame-timeline model predicts every output per cycle,
// with literal expectations pinning key timings from the frame arithmetic.
module tb_hi_reader_seq;

  localparam int E  = 128;
  localparam int BC = 8 * E;

  logic        ck_1356meg = 1'b1;
  logic        rst_n      = 1'b1;
  logic        start      = 1'b0;
  logic        shallow    = 1'b0;
  logic        rx_done    = 1'b0;
  logic [15:0] fdt        = 16'd0;
  logic [15:0] rx_window  = 16'd0;
  logic [3:0]  minor_mode;
  logic        mod_out, busy, done, timeout, err;

  hi_reader_seq_if tx ();

  hi_reader_seq #(.ETU_CLKS(E)) dut (
    .ck_1356meg (ck_1356meg),
    .rst_n      (rst_n),
    .start      (start),
    .shallow    (shallow),
    .tx         (tx),
    .fdt        (fdt),
    .rx_window  (rx_window),
    .rx_done    (rx_done),
    .minor_mode (minor_mode),
    .mod_out    (mod_out),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .err        (err)
  );

  always #5 ck_1356meg = ~ck_1356meg;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Current frame description
  logic [7:0] f_bytes [4];
  int f_nb, f_fdt, f_win, f_rxd, f_abort;
  bit f_sh, f_under, f_hold, f_gnoise;

  logic [9:0] exp_vec;
  bit         exp_on = 1'b0;
  int         cur_c  = 0;
  int st_txm, st_mod, st_rdy, st_rdy_c, st_dn_c, st_to_c, st_er_c;

  // Expected {minor_mode, mod_out, tx_ready, busy, done, timeout, err} at frame cycle c
  // (c = 0 is the first cycle after start was taken, the byte-request cycle).
  function automatic logic [9:0] model(input int c);
    logic [3:0] mm;
    logic md, rdy, bsy, dn, to, er;
    int t_len, i, b, bi, r0, limit, end_r;
    mm = 4'd0; md = 0; rdy = 0; bsy = 0; dn = 0; to = 0; er = 0;
    t_len = f_nb * BC;
    r0    = t_len + 1 + f_fdt;
    limit = (f_win == 0) ? 0 : f_win - 1;
    end_r = (f_rxd >= 0 && f_rxd <= limit) ? f_rxd : limit;
    if (c == 0) begin
      bsy = 1; rdy = 1;
    end else if (c <= t_len) begin
      i   = c - 1;
      b   = i / BC;
      bi  = (i / E) % 8;
      bsy = 1;
      mm  = f_sh ? 4'd5 : 4'd4;
      md  = f_bytes[b][bi];
      rdy = (i % BC == BC - 1) && ((b < f_nb - 1) || f_under);
    end else if (f_under) begin
      er = (c == t_len + 1);
    end else if (c < r0) begin
      bsy = 1;
    end else if (c - r0 <= end_r) begin
      bsy = 1;
    end else if (c - r0 == end_r + 1) begin
      if (f_rxd >= 0 && f_rxd <= limit) dn = 1;
      else to = 1;
    end
    return {mm, md, rdy, bsy, dn, to, er};
  endfunction

  // Inputs seen at the end of frame cycle c
  task automatic drive(input int c);
    int t_len, i, b, r0;
    t_len = f_nb * BC;
    r0    = t_len + 1 + f_fdt;
    start = 1'b0; rx_done = 1'b0;
    tx.tx_valid = 1'b0; tx.tx_last = 1'b0; tx.tx_byte = 8'h00;
    if (c == 0) begin
      tx.tx_valid = 1'b1;
      tx.tx_byte  = f_bytes[0];
      tx.tx_last  = (f_nb == 1) && !f_under;
      // Frame parameters must already be latched; disturb them.
      shallow = ~f_sh; fdt = 16'hFFFF; rx_window = 16'hFFFF;
    end else if (c <= t_len) begin
      i = c - 1;
      b = i / BC;
      if (i % BC == BC - 1 && b < f_nb - 1) begin
        tx.tx_valid = 1'b1;
        tx.tx_byte  = f_bytes[b + 1];
        tx.tx_last  = (b + 1 == f_nb - 1) && !f_under;
      end
      if (f_hold) start = 1'b1;
    end else if (!f_under) begin
      if (c < r0 && f_gnoise) rx_done = 1'b1;
      if (c >= r0 && c - r0 == f_rxd) rx_done = 1'b1;
    end
  endtask

  task automatic run_frame();
    int t_len, r0, limit, end_r, c_end;
    t_len = f_nb * BC;
    r0    = t_len + 1 + f_fdt;
    limit = (f_win == 0) ? 0 : f_win - 1;
    end_r = (f_rxd >= 0 && f_rxd <= limit) ? f_rxd : limit;
    c_end = f_under ? t_len + 1 : r0 + end_r + 1;
    st_txm = 0; st_mod = 0; st_rdy = 0;
    st_rdy_c = -1; st_dn_c = -1; st_to_c = -1; st_er_c = -1;
    @(posedge ck_1356meg); #1;
    start = 1'b1; shallow = f_sh;
    fdt = 16'(f_fdt); rx_window = 16'(f_win);
    exp_vec = model(0); cur_c = 0; exp_on = 1'b1;
    for (int c = 0; c <= c_end + 2; c++) begin
      @(posedge ck_1356meg); #1;
      if (c == f_abort) break;
      drive(c);
      exp_vec = model(c + 1);
      cur_c   = c + 1;
    end
    exp_on = 1'b0;
    start = 1'b0; rx_done = 1'b0; tx.tx_valid = 1'b0;
  endtask

  task automatic set_frame(input logic [7:0] b0, input logic [7:0] b1, input int nb,
                           input bit sh, input int fd, input int win, input int rxd);
    f_bytes[0] = b0; f_bytes[1] = b1; f_bytes[2] = 8'h00; f_bytes[3] = 8'h00;
    f_nb = nb; f_sh = sh; f_fdt = fd; f_win = win; f_rxd = rxd;
    f_under = 0; f_hold = 0; f_gnoise = 0; f_abort = -1;
  endtask

  // Per-cycle compare against the model, plus frame statistics
  always @(posedge ck_1356meg) begin
    if (exp_on) begin
      check($sformatf("c=%0d {mode,mod,rdy,busy,done,to,err}", cur_c),
            {22'd0, minor_mode, mod_out, tx.tx_ready, busy, done, timeout, err},
            {22'd0, exp_vec});
      if (minor_mode == 4'd4 || minor_mode == 4'd5) st_txm++;
      if (mod_out) st_mod++;
      if (cur_c > 0 && tx.tx_ready) begin st_rdy++; st_rdy_c = cur_c; end
      if (done)    st_dn_c = cur_c;
      if (timeout) st_to_c = cur_c;
      if (err)     st_er_c = cur_c;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tx.tx_valid = 1'b0; tx.tx_last = 1'b0; tx.tx_byte = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge ck_1356meg);
    check("reset state", {22'd0, minor_mode, mod_out, tx.tx_ready, busy, done, timeout, err}, 32'd0);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge ck_1356meg);

    // 1: 0xA5 full mod, fdt=10, window 100, timeout
    set_frame(8'hA5, 8'h00, 1, 0, 10, 100, -1);
    run_frame();
    check("f1 send-mode cycles", st_txm, 1024);
    check("f1 mod_out high cycles", st_mod, 512);
    check("f1 timeout cycle", st_to_c, 1135);

    // 2: 0x01,0x80 back-to-back, shallow
    set_frame(8'h01, 8'h80, 2, 1, 3, 50, -1);
    run_frame();
    check("f2 shallow-mode cycles", st_txm, 2048);
    check("f2 mod_out high cycles", st_mod, 256);
    check("f2 tx_ready pulses in TX", st_rdy, 1);
    check("f2 tx_ready cycle", st_rdy_c, 1024);

    // 3: underrun after a non-final byte
    set_frame(8'h3C, 8'h00, 1, 0, 10, 100, -1);
    f_under = 1;
    run_frame();
    check("f3 err cycle", st_er_c, 1025);
    check("f3 no done/timeout", {30'd0, st_dn_c == -1, st_to_c == -1}, 32'd3);

    // 4: rx_done 5 cycles into RX, rx_done noise during GUARD
    set_frame(8'h5A, 8'h00, 1, 0, 4, 100, 5);
    f_gnoise = 1;
    run_frame();
    check("f4 done cycle", st_dn_c, 1035);

    // 5: rx_done coincident with window expiry
    set_frame(8'hC3, 8'h00, 1, 1, 2, 20, 19);
    run_frame();
    check("f5 done cycle", st_dn_c, 1047);
    check("f5 no timeout", st_to_c, -1);

    // 6: fdt=0, rx_window=0
    set_frame(8'h77, 8'h00, 1, 0, 0, 0, -1);
    run_frame();
    check("f6 timeout cycle", st_to_c, 1026);

    // 7: start held during TX, then reset mid-TX
    set_frame(8'hFF, 8'hFF, 2, 0, 10, 100, -1);
    f_hold = 1; f_abort = 300;
    run_frame();
    check("f7 mod_out high before reset", st_mod, 300);
    start = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("async reset outputs", {22'd0, minor_mode, mod_out, tx.tx_ready, busy, done, timeout, err}, 32'd0);
    repeat (3) begin
      @(posedge ck_1356meg);
      check("reset held outputs", {22'd0, minor_mode, mod_out, tx.tx_ready, busy, done, timeout, err}, 32'd0);
    end
    #1 start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge ck_1356meg);

    // 8: clean frame after reset
    set_frame(8'h96, 8'h00, 1, 0, 5, 30, -1);
    run_frame();
    check("f8 mod_out high cycles", st_mod, 512);
    check("f8 timeout cycle", st_to_c, 1060);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hi_reader_seq.md
Name: hi_reader_seq

Overview:
- Frame sequencer for the HF reader datapath.
- Serialises reader command bytes into a modulation bit stream, which drives the reader's ssp_dout modulation input.
- Drives the reader's minor_mode: send mode during TX, then an idle guard (frame delay time), then a receive window with timeout.
- Sits between the ARM-facing command path and the HF reader correlator block. Replaces ad-hoc ARM bit-banging of mode/modulation timing.

Parameters:
- ETU_CLKS, 128, carrier clocks per transmitted bit (106 kbit/s at 13.56 MHz); minimum 2.
- MODE_RX, 4'd0, minor_mode code for receive (FPGA_HF_READER_MODE_RECEIVE_IQ value).
- MODE_FULL, 4'd4, minor_mode code for full modulation (FPGA_HF_READER_MODE_SEND_FULL_MOD value).
- MODE_SHALLOW, 4'd5, minor_mode code for shallow modulation (FPGA_HF_READER_MODE_SEND_SHALLOW_MOD value).

Ports:
- ck_1356meg  in  1  13.56 MHz carrier clock; all logic on its negedge, matching the ADC/SSP domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle frame start request.
- shallow  in  1  1 = shallow modulation, 0 = full; sampled at start.
- tx_byte  in  8  command byte, sent LSB first.
- tx_valid  in  1  tx_byte valid.
- tx_last  in  1  qualifies tx_byte as the final byte of the frame.
- tx_ready  out  1  byte accepted this cycle when tx_valid & tx_ready.
- fdt  in  16  guard length in clocks; sampled at start.
- rx_window  in  16  receive timeout in clocks; sampled at start.
- rx_done  in  1  end-of-response indication from the demod path.
- minor_mode  out  4  mode code for the reader datapath.
- mod_out  out  1  modulation bit to the reader (1 = modulate).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse: frame ended via rx_done.
- timeout  out  1  one-cycle pulse: receive window expired.
- err  out  1  one-cycle pulse: TX underrun abort.

Behaviour:
- Reset values: state IDLE, minor_mode=MODE_RX, mod_out=0, tx_ready=0, busy/done/timeout/err=0, all counters 0.
- Reset mid-frame aborts immediately to these values. No pulse is emitted.
- FSM states: IDLE, LOAD, TX, GUARD, RX.
- IDLE:
  - minor_mode=MODE_RX (carrier on); mod_out=0.
  - start=1 latches shallow, fdt and rx_window, then enters LOAD next cycle.
- LOAD:
  - tx_ready=1; waits indefinitely for tx_valid.
  - On accept: load shift register, latch tx_last, bit_cnt=0, etu_cnt=0, enter TX.
  - minor_mode stays MODE_RX while waiting.
- TX:
  - minor_mode = shallow ? MODE_SHALLOW : MODE_FULL.
  - mod_out = shift[0], registered; it is valid the first TX cycle.
  - Each bit is held exactly ETU_CLKS cycles. etu_cnt counts 0..ETU_CLKS-1, then the register shifts right and bit_cnt increments.
  - A byte lasts 8*ETU_CLKS cycles.
  - tx_ready=1 only on the last cycle of bit 7, and only when the latched tx_last=0.
    - If tx_valid=1 there: load the next byte; the next cycle is bit 0 of that byte (no gap).
    - If tx_valid=0 there: pulse err and return to IDLE. mod_out=0 and minor_mode=MODE_RX from the next cycle.
  - After the last cycle of bit 7 of a tx_last byte: enter GUARD with guard counter = 0.
- GUARD:
  - mod_out=0; minor_mode=MODE_RX.
  - Lasts exactly fdt cycles. fdt=0 skips GUARD: RX begins the cycle after TX ends.
  - rx_done is ignored in GUARD.
- RX:
  - minor_mode=MODE_RX; window counter counts from 0.
  - rx_done=1 pulses done and returns to IDLE.
  - Otherwise, when the counter reaches rx_window-1, pulse timeout and return to IDLE. rx_window=0 times out on the first RX cycle.
  - rx_done on the same cycle as expiry: done wins; timeout stays 0.
- start while busy=1 is ignored; it does not queue.
- Counters are 16 bits and saturate free. No wrap is possible since fdt and rx_window are at most 65535.
- Latency: start at cycle N → LOAD at N+1 → first TX cycle one cycle after the accept.
- Total frame length (TX to GUARD): bytes*8*ETU_CLKS cycles, exact.
- Output pulses are registered and last exactly one cycle. busy falls on the same cycle as the pulse.

Test Plan:
- Single byte 0xA5, tx_last=1, shallow=0, fdt=10, rx_window=100, no rx_done:
  - mod_out pattern 1,0,1,0,0,1,0,1, each held 128 cycles, minor_mode=4 for 1024 cycles.
  - Then 10 cycles of mode 0, then timeout pulse exactly 100 cycles later; busy low after.
- Two bytes 0x01, 0x80 back-to-back, shallow=1:
  - tx_ready pulses once, at cycle 1023 of TX; minor_mode=5 for 2048 contiguous cycles.
  - mod_out high for cycles 0-127 and 1920-2047 only.
- Underrun: first byte tx_last=0, tx_valid low at byte boundary → err pulse at TX cycle 1023; IDLE; mod_out=0; no done/timeout.
- rx_done asserted 5 cycles into RX, and separately coincident with expiry (rx_window=20, rx_done at RX cycle 19) → done pulse only in both cases.
- fdt=0 and rx_window=0 → RX entered the cycle after TX, timeout on that first RX cycle.
- start held during TX, and rst_n dropped mid-TX → start has no effect; reset forces minor_mode=0, mod_out=0 asynchronously, with no pulses; a new start afterwards runs a clean frame.
